// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ps2_pkg
// Purpose  : Shared definitions for the PS/2 device transmitter: the FSM
//            state encoding, the frame length, and the frame bit helpers.
// Contents : state_t, FRAME_BITS, c_parity_idx, odd_parity(), frame_bit()
// Revision : 1.0 - initial release
// ============================================================================
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // Start + 8 data + parity + stop
  localparam int FRAME_BITS = 11;

  // Position of the parity bit inside the frame (0 = start bit)
  localparam logic [3:0] c_parity_idx = 4'd9;

  function automatic logic odd_parity(input logic [7:0] data);
    return ~^data;
  endfunction

  // Value of frame bit idx for a given byte: start 0, d0..d7, parity, stop 1
  function automatic logic frame_bit(input logic [7:0] data, input logic [3:0] idx);
    logic b;
    b = 1'b1;
    if (idx == 4'd0) begin
      b = 1'b0;
    end else if (idx <= 4'd8) begin
      b = data[3'(idx - 4'd1)];
    end else if (idx == c_parity_idx) begin
      b = odd_parity(data);
    end
    return b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_fifo.sv
`default_nettype none
// ============================================================================
// Module   : ps2_fifo
// Purpose  : Byte FIFO for queued scancodes. The head stays visible on
//            'head' until popped, so a frame can be replayed after an abort.
// Ports    : clock, resetn      - clock, async active-low reset
//            push, push_data    - write request (ignored when full)
//            pop                - remove head (ignored when empty)
//            head               - oldest byte
//            full, empty, level - occupancy status
// Revision : 1.0 - initial release
// ============================================================================
module ps2_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic [7:0]               head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int c_aw = $clog2(DEPTH);
  localparam logic [c_aw:0] c_full_level = (c_aw + 1)'(DEPTH);

  logic [7:0]      r_mem [DEPTH];
  logic [c_aw-1:0] r_wr_ptr;
  logic [c_aw-1:0] r_rd_ptr;
  logic [c_aw:0]   r_level;
  logic            w_push;
  logic            w_pop;

  assign full   = (r_level == c_full_level);
  assign empty  = (r_level == '0);
  assign level  = r_level;
  assign head   = r_mem[r_rd_ptr];
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  // Storage carries no reset; occupancy is tracked by the pointers alone.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_aw'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_aw'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (c_aw + 1)'(1);
        2'b01:   r_level <= r_level - (c_aw + 1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/ps2_dev_tx.sv
`default_nettype none
// ============================================================================
// Module   : ps2_dev_tx
// Purpose  : PS/2 device-to-host transmitter. Queues scancode bytes and
//            serialises each as an 11-bit frame (start, d0..d7, odd parity,
//            stop), honouring host inhibit with abort-and-retry.
// Ports    : clock, resetn          - clock, async-assert active-low reset
//            in_valid/in_data/in_ready - byte input handshake
//            inhibit                - host holding PS/2 clock low (async)
//            ps2_clk, ps2_dat       - device-driven PS/2 lines
//            fifo_level             - bytes queued incl. the one in flight
//            frame_done             - one-cycle pulse at end of stop bit
//            busy                   - FSM not idle
// Revision : 1.0 - initial release
// ============================================================================
module ps2_dev_tx
  import ps2_pkg::*;
#(
  parameter int HALF_DIV    = 4,
  parameter int FIFO_DEPTH  = 8,
  parameter int GAP_PERIODS = 2
) (
  input  logic                          clock,
  input  logic                          resetn,
  input  logic                          in_valid,
  input  logic [7:0]                    in_data,
  output logic                          in_ready,
  input  logic                          inhibit,
  output logic                          ps2_clk,
  output logic                          ps2_dat,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          frame_done,
  output logic                          busy
);

  localparam int c_bit_cycles = 2 * HALF_DIV;
  localparam int c_gap_cycles = GAP_PERIODS * 2 * HALF_DIV;
  localparam int c_cnt_max    = (c_gap_cycles > c_bit_cycles) ? c_gap_cycles : c_bit_cycles;
  localparam int c_cnt_w      = $clog2(c_cnt_max + 1);

  localparam logic [c_cnt_w-1:0] c_half     = c_cnt_w'(HALF_DIV);
  localparam logic [c_cnt_w-1:0] c_bit_last = c_cnt_w'(c_bit_cycles - 1);
  localparam logic [c_cnt_w-1:0] c_gap_last = c_cnt_w'(c_gap_cycles - 1);
  localparam logic [3:0]         c_bit_end  = 4'(FRAME_BITS - 1);

  // Reset: asserts immediately, releases on a clock edge.
  logic [1:0] r_rst_sync;
  logic       w_rst_n;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_rst_n = r_rst_sync[1];

  // Inhibit synchroniser
  logic r_inh_meta;
  logic r_inh_sync;

  always_ff @(posedge clock or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_inh_meta <= 1'b0;
      r_inh_sync <= 1'b0;
    end else begin
      r_inh_meta <= inhibit;
      r_inh_sync <= r_inh_meta;
    end
  end

  // FIFO
  logic       w_push;
  logic       w_pop;
  logic [7:0] w_head;
  logic       w_full;
  logic       w_empty;

  assign in_ready = !w_full;
  assign w_push   = in_valid && !w_full;

  ps2_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .resetn    (w_rst_n),
    .push      (w_push),
    .push_data (in_data),
    .pop       (w_pop),
    .head      (w_head),
    .full      (w_full),
    .empty     (w_empty),
    .level     (fifo_level)
  );

  // FSM
  state_t               r_state;
  state_t               w_state_nxt;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [c_cnt_w-1:0]   w_cnt_nxt;
  logic [c_cnt_w-1:0]   w_cnt_inc;
  logic [3:0]           r_bit;
  logic [3:0]           w_bit_nxt;
  logic                 r_ps2_clk;
  logic                 w_clk_nxt;
  logic                 r_ps2_dat;
  logic                 w_dat_nxt;
  logic                 r_frame_done;
  logic                 w_done_nxt;
  logic                 w_can_start;
  logic                 w_abort;

  assign w_can_start = !w_empty && !r_inh_sync;
  assign w_cnt_inc   = r_cnt + c_cnt_w'(1);

  // Abort is only allowed up to the last high cycle of the parity bit; once
  // the parity low phase has begun the host has latched enough to expect
  // the frame to finish.
  assign w_abort = r_inh_sync &&
                   ((r_bit < c_parity_idx) ||
                    ((r_bit == c_parity_idx) && (r_cnt < c_half)));

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_bit_nxt   = r_bit;
    w_clk_nxt   = 1'b1;
    w_dat_nxt   = 1'b1;
    w_done_nxt  = 1'b0;
    w_pop       = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_can_start) begin
          w_state_nxt = ST_SEND;
          w_cnt_nxt   = '0;
          w_bit_nxt   = 4'd0;
          w_dat_nxt   = 1'b0;
        end
      end

      ST_SEND: begin
        if (w_abort) begin
          // Byte remains at the FIFO head and is resent from the start bit.
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
          w_bit_nxt   = 4'd0;
        end else if (r_cnt == c_bit_last) begin
          if (r_bit == c_bit_end) begin
            w_done_nxt  = 1'b1;
            w_pop       = 1'b1;
            w_cnt_nxt   = '0;
            w_bit_nxt   = 4'd0;
            w_state_nxt = (c_gap_cycles == 0) ? ST_IDLE : ST_GAP;
          end else begin
            w_bit_nxt = r_bit + 4'd1;
            w_cnt_nxt = '0;
            w_dat_nxt = frame_bit(w_head, r_bit + 4'd1);
          end
        end else begin
          // Data is held for the whole bit; only the clock toggles.
          w_cnt_nxt = w_cnt_inc;
          w_clk_nxt = (w_cnt_inc < c_half);
          w_dat_nxt = r_ps2_dat;
        end
      end

      ST_GAP: begin
        if (r_cnt == c_gap_last) begin
          w_cnt_nxt = '0;
          if (w_can_start) begin
            w_state_nxt = ST_SEND;
            w_bit_nxt   = 4'd0;
            w_dat_nxt   = 1'b0;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
        w_bit_nxt   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_bit        <= 4'd0;
      r_ps2_clk    <= 1'b1;
      r_ps2_dat    <= 1'b1;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_bit        <= w_bit_nxt;
      r_ps2_clk    <= w_clk_nxt;
      r_ps2_dat    <= w_dat_nxt;
      r_frame_done <= w_done_nxt;
    end
  end

  assign ps2_clk    = r_ps2_clk;
  assign ps2_dat    = r_ps2_dat;
  assign frame_done = r_frame_done;
  assign busy       = (r_state != ST_IDLE);

endmodule
`default_nettype wire
